// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, limits and requester IDs
// for the kernel/weight memory port arbiter.
`ifndef numAddr
`define numAddr 5
`endif

package nn_pkg;

  localparam int ADDR_W_DEF   = `numAddr;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_LOCK_DEF = 32;

  typedef enum logic {
    REQ_LOAD     = 1'b0,
    REQ_CLASSIFY = 1'b1
  } req_id_e;

  function automatic logic [1:0] id2oh(
    input req_id_e id
  );
    return (id == REQ_CLASSIFY) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/kmem_port_arbiter_if.sv
// kmem_port_arbiter_if: requester-side command
// bus plus the RAM port it is arbitrated onto.
interface kmem_port_arbiter_if
  import nn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        lock;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] MEM_ADD;
  logic              MEM_CSB;
  logic              MEM_WEB;
  logic              MEM_OEB;
  logic [DATA_W-1:0] MEM_I;
  logic [DATA_W-1:0] MEM_O;

  modport master (
    output req, we, lock,
    output addr0, addr1,
    output wdata0, wdata1,
    output MEM_O,
    input  gnt, rvalid, rdata,
    input  MEM_ADD, MEM_CSB,
    input  MEM_WEB, MEM_OEB,
    input  MEM_I
  );

  modport slave (
    input  req, we, lock,
    input  addr0, addr1,
    input  wdata0, wdata1,
    input  MEM_O,
    output gnt, rvalid, rdata,
    output MEM_ADD, MEM_CSB,
    output MEM_WEB, MEM_OEB,
    output MEM_I
  );

endinterface

// File: rtl/kmem_port_arbiter_rr_lock_arb.sv
// rr_lock_arb: 2-way round-robin grant with a
// bounded burst lock for the current owner.
module rr_lock_arb
  import nn_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_LOCK);

  req_id_e       r_last;
  logic          r_own_vld;
  req_id_e       r_own;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_gnt;
  logic [1:0]    w_tie;
  logic          w_hold;
  logic          w_any;
  logic          w_lock;
  logic          w_oth_req;
  logic          w_keep;
  req_id_e       w_gid;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_cnt_n;

  // grant: single requester wins, ties go to owner or round-robin
  always_comb begin
    w_hold = r_own_vld && (r_cnt < CMAX);
    w_tie  = w_hold ? id2oh(r_own)
                    : id2oh(req_id_e'(~r_last));
    w_gnt  = 2'b00;
    if (!rst) begin
      unique case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = w_tie;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // next lock count: restarts when ownership changes hands
  always_comb begin
    w_any     = |w_gnt;
    w_gid     = req_id_e'(w_gnt[1]);
    w_lock    = |(w_gnt & i_lock);
    w_oth_req = w_gnt[1] ? i_req[0] : i_req[1];
    w_keep    = r_own_vld && (r_own == w_gid);
    w_base    = w_keep ? r_cnt : '0;
    w_cnt_n   = w_base;
    if (w_oth_req && (w_base != CMAX))
      w_cnt_n = w_base + CW'(1);
  end

  // owner, lock counter and last-grant state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= REQ_CLASSIFY;
      r_own_vld <= 1'b0;
      r_own     <= REQ_LOAD;
      r_cnt     <= '0;
    end else begin
      if (w_any)
        r_last <= w_gid;
      if (w_any && w_lock) begin
        r_own_vld <= 1'b1;
        r_own     <= w_gid;
        r_cnt     <= w_cnt_n;
      end else begin
        r_own_vld <= 1'b0;
        r_cnt     <= '0;
      end
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/kmem_port_arbiter.sv
// kmem_port_arbiter: shares one RAM port between
// loader and classifier, tagging read returns.
module kmem_port_arbiter
  import nn_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input logic           clk,
  input logic           rst,
  kmem_port_arbiter_if.slave bus
);

  logic [1:0]        w_gnt;
  req_id_e           w_gid;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rd_cmd;

  logic              r_csb;
  logic              r_web;
  logic              r_oeb;
  logic [ADDR_W-1:0] r_add;
  logic [DATA_W-1:0] r_i;
  req_id_e           r_cmd_id;
  logic [RD_LAT-1:0] r_tag_v;
  logic [RD_LAT-1:0] r_tag_id;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  rr_lock_arb #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  (bus.req),
    .i_lock (bus.lock),
    .o_gnt  (w_gnt)
  );

  // mux the granted requester's command
  always_comb begin
    w_gid   = REQ_LOAD;
    w_addr  = bus.addr0;
    w_wdata = bus.wdata0;
    w_we    = bus.we[0];
    unique case (1'b1)
      w_gnt[1]: begin
        w_gid   = REQ_CLASSIFY;
        w_addr  = bus.addr1;
        w_wdata = bus.wdata1;
        w_we    = bus.we[1];
      end
      default: ;
    endcase
  end

  // registered active-low RAM command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csb    <= 1'b1;
      r_web    <= 1'b1;
      r_oeb    <= 1'b1;
      r_add    <= '0;
      r_i      <= '0;
      r_cmd_id <= REQ_LOAD;
    end else if (|w_gnt) begin
      r_csb    <= 1'b0;
      r_add    <= w_addr;
      r_web    <= ~w_we;
      r_oeb    <= w_we;
      r_cmd_id <= w_gid;
      if (w_we)
        r_i <= w_wdata;
    end else begin
      r_csb <= 1'b1;
      r_web <= 1'b1;
      r_oeb <= 1'b1;
    end
  end

  assign w_rd_cmd = ~r_csb & r_web & ~r_oeb;

  // read tag pipeline, aligned with RAM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_rd_cmd;
      r_tag_id[0] <= r_cmd_id;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // capture RAM data and pulse the owner's rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 2'b00;
      if (r_tag_v[RD_LAT-1]) begin
        r_rvalid <= r_tag_id[RD_LAT-1] ? 2'b10
                                       : 2'b01;
        r_rdata  <= bus.MEM_O;
      end
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.MEM_CSB = r_csb;
  assign bus.MEM_WEB = r_web;
  assign bus.MEM_OEB = r_oeb;
  assign bus.MEM_ADD = r_add;
  assign bus.MEM_I   = r_i;

endmodule

// File: tb/tb_kmem_port_arbiter.sv
// tb_kmem_port_arbiter: two DUTs (RD_LAT 1 and 2)
// on shared stimulus, checked against a reference model.
module tb_kmem_port_arbiter;
  import nn_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int ML = 4;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          s_rst;
  logic [1:0]    s_req;
  logic [1:0]    s_we;
  logic [1:0]    s_lock;
  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_wd [2];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int            m_last;
  int            m_own;
  bit            m_own_v;
  int            m_cnt;
  logic          m_csb, m_web, m_oeb;
  logic [AW-1:0] m_add;
  logic [DW-1:0] m_i;
  logic [DW-1:0] ref_mem [32] = '{default: '0};
  rd_t           q0 [$];
  rd_t           q1 [$];
  logic [1:0]    exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  bit            fresh [2];

  logic [DW-1:0] ram0 [32] = '{default: '0};
  logic [DW-1:0] ram1 [32] = '{default: '0};
  logic [DW-1:0] r_p1 = '0;

  kmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if0 ();
  kmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if1 ();

  kmem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_LOCK(ML)
  ) u_dut0 (
    .clk (clk), .rst (s_rst), .bus (u_if0)
  );

  kmem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_LOCK(ML)
  ) u_dut1 (
    .clk (clk), .rst (s_rst), .bus (u_if1)
  );

  always #5 clk = ~clk;

  assign u_if0.req    = s_req;
  assign u_if0.we     = s_we;
  assign u_if0.lock   = s_lock;
  assign u_if0.addr0  = s_addr[0];
  assign u_if0.addr1  = s_addr[1];
  assign u_if0.wdata0 = s_wd[0];
  assign u_if0.wdata1 = s_wd[1];
  assign u_if1.req    = s_req;
  assign u_if1.we     = s_we;
  assign u_if1.lock   = s_lock;
  assign u_if1.addr0  = s_addr[0];
  assign u_if1.addr1  = s_addr[1];
  assign u_if1.wdata0 = s_wd[0];
  assign u_if1.wdata1 = s_wd[1];

  // RAM behind DUT0: data one cycle after command
  always @(posedge clk) begin
    if (!u_if0.MEM_CSB && !u_if0.MEM_WEB)
      ram0[u_if0.MEM_ADD] <= u_if0.MEM_I;
    if (!u_if0.MEM_CSB && u_if0.MEM_WEB && !u_if0.MEM_OEB)
      u_if0.MEM_O <= ram0[u_if0.MEM_ADD];
  end

  // RAM behind DUT1: data two cycles after command
  always @(posedge clk) begin
    if (!u_if1.MEM_CSB && !u_if1.MEM_WEB)
      ram1[u_if1.MEM_ADD] <= u_if1.MEM_I;
    if (!u_if1.MEM_CSB && u_if1.MEM_WEB && !u_if1.MEM_OEB)
      r_p1 <= ram1[u_if1.MEM_ADD];
    u_if1.MEM_O <= r_p1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic int m_grant();
    if (s_rst) return -1;
    if (s_req == 2'b01) return 0;
    if (s_req == 2'b10) return 1;
    if (s_req == 2'b11) begin
      if (m_own_v && m_cnt < ML) return m_own;
      return 1 - m_last;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_last  = 1;
    m_own   = 0;
    m_own_v = 0;
    m_cnt   = 0;
    m_csb   = 1'b1;
    m_web   = 1'b1;
    m_oeb   = 1'b1;
    m_add   = '0;
    m_i     = '0;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      exp_rv[d] = 2'b00;
      exp_rd[d] = '0;
      fresh[d]  = 1'b1;
    end
  endtask

  task automatic m_pop(input int d);
    rd_t e;
    exp_rv[d] = 2'b00;
    if (d == 0 && q0.size() > 0 && q0[0].due == cyc)
      e = q0.pop_front();
    else if (d == 1 && q1.size() > 0 && q1[0].due == cyc)
      e = q1.pop_front();
    else
      return;
    exp_rv[d] = (e.id == 1) ? 2'b10 : 2'b01;
    exp_rd[d] = e.data;
    fresh[d]  = 1'b0;
  endtask

  task automatic m_edge(input int g);
    rd_t e;
    cyc++;
    if (s_rst) begin
      m_reset();
      return;
    end
    if (g >= 0) m_last = g;
    if (m_own_v && ((g == m_own && !s_lock[m_own]) ||
                    !s_req[m_own] ||
                    (g >= 0 && g != m_own))) begin
      m_own_v = 0;
      m_cnt   = 0;
    end
    if (g >= 0 && s_lock[g]) begin
      if (!(m_own_v && m_own == g)) begin
        m_own_v = 1;
        m_own   = g;
        m_cnt   = 0;
      end
      if (s_req[1-g] && m_cnt < ML) m_cnt++;
    end
    if (g >= 0) begin
      m_csb = 1'b0;
      m_add = s_addr[g];
      m_web = !s_we[g];
      m_oeb = s_we[g];
      if (s_we[g]) begin
        m_i = s_wd[g];
        ref_mem[s_addr[g]] = s_wd[g];
      end else begin
        e = '{cyc + 2, g, ref_mem[s_addr[g]]};
        q0.push_back(e);
        e.due = cyc + 3;
        q1.push_back(e);
      end
    end else begin
      m_csb = 1'b1;
      m_web = 1'b1;
      m_oeb = 1'b1;
    end
    m_pop(0);
    m_pop(1);
  endtask

  task automatic chk_port(input string nm, input int d,
                          input logic csb, input logic web,
                          input logic oeb,
                          input logic [AW-1:0] add,
                          input logic [DW-1:0] mi,
                          input logic [1:0] rv,
                          input logic [DW-1:0] rd);
    chk({nm, ".csb"}, 32'(csb), 32'(m_csb));
    chk({nm, ".web"}, 32'(web), 32'(m_web));
    chk({nm, ".oeb"}, 32'(oeb), 32'(m_oeb));
    chk({nm, ".add"}, 32'(add), 32'(m_add));
    chk({nm, ".memi"}, mi, m_i);
    chk({nm, ".rvalid"}, 32'(rv), 32'(exp_rv[d]));
    if (exp_rv[d] != 2'b00 || fresh[d])
      chk({nm, ".rdata"}, rd, exp_rd[d]);
  endtask

  task automatic step();
    int         g;
    logic [1:0] eg;
    #1;
    g  = m_grant();
    eg = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    chk("d0.gnt", 32'(u_if0.gnt), 32'(eg));
    chk("d1.gnt", 32'(u_if1.gnt), 32'(eg));
    @(posedge clk);
    m_edge(g);
    @(negedge clk);
    chk_port("d0", 0, u_if0.MEM_CSB, u_if0.MEM_WEB,
             u_if0.MEM_OEB, u_if0.MEM_ADD, u_if0.MEM_I,
             u_if0.rvalid, u_if0.rdata);
    chk_port("d1", 1, u_if1.MEM_CSB, u_if1.MEM_WEB,
             u_if1.MEM_OEB, u_if1.MEM_ADD, u_if1.MEM_I,
             u_if1.rvalid, u_if1.rdata);
  endtask

  task automatic idle(input int n);
    s_req = 2'b00;
    s_lock = 2'b00;
    repeat (n) step();
  endtask

  initial begin
    m_reset();
    s_rst  = 1'b1;
    s_req  = 2'b00;
    s_we   = 2'b00;
    s_lock = 2'b00;
    for (int i = 0; i < 2; i++) begin
      s_addr[i] = '0;
      s_wd[i]   = '0;
    end
    step();
    step();
    s_rst = 1'b0;
    idle(5);

    s_req = 2'b01; s_we = 2'b01;
    s_addr[0] = 5'd3; s_wd[0] = 32'hA5A5_0001;
    step();
    s_req = 2'b10; s_we = 2'b00; s_addr[1] = 5'd3;
    step();
    idle(4);

    s_req = 2'b11; s_we = 2'b00;
    for (int i = 0; i < 6; i++) begin
      s_addr[0] = AW'($urandom);
      s_addr[1] = AW'($urandom);
      step();
    end
    idle(4);

    s_req = 2'b11; s_lock = 2'b01;
    repeat (5) step();
    s_lock = 2'b00;
    repeat (4) step();
    idle(4);

    s_req = 2'b01; s_we = 2'b01;
    for (int i = 0; i < 3; i++) begin
      s_addr[0] = AW'(i);
      s_wd[0]   = 32'h10 + 32'(i);
      step();
    end
    s_req = 2'b10; s_we = 2'b00;
    for (int i = 0; i < 3; i++) begin
      s_addr[1] = AW'(i);
      step();
    end
    idle(5);

    s_req = 2'b10; s_we = 2'b00; s_addr[1] = 5'd5;
    step();
    s_req = 2'b00; s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    idle(5);

    for (int i = 0; i < 600; i++) begin
      s_rst  = ($urandom_range(0, 59) == 0);
      s_req  = 2'($urandom);
      s_we   = 2'($urandom);
      s_lock = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      s_addr[0] = AW'($urandom);
      s_addr[1] = AW'($urandom);
      s_wd[0]   = $urandom;
      s_wd[1]   = $urandom;
      step();
    end
    s_rst = 1'b0;
    idle(6);
    chk("drain0", 32'(q0.size()), 32'd0);
    chk("drain1", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
